// File: rtl/reg_file_param_if.sv
// rtl/reg_file_param_if.sv - request/response bundle of the two-read one-write register file
//
// Purpose: groups every non-clock, non-reset signal of reg_file_param.
// Ports (signals):
//   READ, WRITE, CLEAR          request strobes, sampled on the CLK rising edge
//   ADDR_R1, ADDR_R2, ADDR_W    read port 1/2 and write addresses (ADDR_WIDTH)
//   DATA_W                      write data (DATA_WIDTH)
//   DATA_R1, DATA_R2            registered read data (DATA_WIDTH)
//   RD_VALID                    one-cycle pulse after a read updated DATA_R1/DATA_R2
// Modports: master drives requests, slave (the register file) drives responses.
interface reg_file_param_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  READ;
    logic                  WRITE;
    logic                  CLEAR;
    logic [ADDR_WIDTH-1:0] ADDR_R1;
    logic [ADDR_WIDTH-1:0] ADDR_R2;
    logic [ADDR_WIDTH-1:0] ADDR_W;
    logic [DATA_WIDTH-1:0] DATA_W;
    logic [DATA_WIDTH-1:0] DATA_R1;
    logic [DATA_WIDTH-1:0] DATA_R2;
    logic                  RD_VALID;

    modport master (
        output READ, WRITE, CLEAR, ADDR_R1, ADDR_R2, ADDR_W, DATA_W,
        input  DATA_R1, DATA_R2, RD_VALID
    );

    modport slave (
        input  READ, WRITE, CLEAR, ADDR_R1, ADDR_R2, ADDR_W, DATA_W,
        output DATA_R1, DATA_R2, RD_VALID
    );
endinterface

// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parameterised register file, two registered read ports, one write port
//
// Purpose: DEPTH = 2^ADDR_WIDTH entries of DATA_WIDTH bits with a synchronous
// whole-array clear (clear beats a same-cycle write) and one-cycle read latency.
// Ports:
//   CLK     rising-edge clock for all state
//   RESET   asynchronous active-high reset of storage and read outputs
//   bus     reg_file_param_if.slave: READ/WRITE/CLEAR strobes, ADDR_R1/ADDR_R2/ADDR_W,
//           DATA_W in; DATA_R1/DATA_R2/RD_VALID out
// Build option: REG_FILE_BYPASS_EN - when defined, a read that hits the entry
// being written (or any entry while CLEAR=1) returns the value committed at that
// same edge; otherwise it returns the value stored before the edge.
module reg_file_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    reg_file_param_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_data_r1;
    logic [DATA_WIDTH-1:0] r_data_r2;
    logic                  r_rd_valid;

    logic [DATA_WIDTH-1:0] w_rd1;
    logic [DATA_WIDTH-1:0] w_rd2;

    // Value each read port captures at the coming edge.
    always_comb begin
        w_rd1 = r_mem[bus.ADDR_R1];
        w_rd2 = r_mem[bus.ADDR_R2];
`ifdef REG_FILE_BYPASS_EN
        // Forward the committed value: clear zeroes every entry, otherwise a
        // write only affects the port whose address matches.
        if (bus.CLEAR) begin
            w_rd1 = '0;
            w_rd2 = '0;
        end else if (bus.WRITE) begin
            if (bus.ADDR_W == bus.ADDR_R1) begin
                w_rd1 = bus.DATA_W;
            end
            if (bus.ADDR_W == bus.ADDR_R2) begin
                w_rd2 = bus.DATA_W;
            end
        end
`endif
    end

    // Storage: clear has priority over write.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (bus.CLEAR) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (bus.WRITE) begin
            r_mem[bus.ADDR_W] <= bus.DATA_W;
        end
    end

    // Read registers hold their data when no read is requested.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_data_r1  <= '0;
            r_data_r2  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= bus.READ;
            if (bus.READ) begin
                r_data_r1 <= w_rd1;
                r_data_r2 <= w_rd2;
            end
        end
    end

    assign bus.DATA_R1  = r_data_r1;
    assign bus.DATA_R2  = r_data_r2;
    assign bus.RD_VALID = r_rd_valid;
endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - self-checking bench for reg_file_param (default and 8x4 builds)
module tb_reg_file_param;
    bit clk = 1'b0;
    bit rst = 1'b0;
    bit cmp_en = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();
    reg_file_param_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(2)) bus8 ();

    reg_file_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) u_dut (
        .CLK(clk), .RESET(rst), .bus(bus)
    );

    reg_file_param #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) u_dut8 (
        .CLK(clk), .RESET(rst), .bus(bus8)
    );

    // Reference model: array of words plus the three output values.
    logic [31:0] m_mem [32];
    logic [31:0] m_r1;
    logic [31:0] m_r2;
    logic        m_v;

    function automatic logic [31:0] model_read(input logic [4:0] a);
`ifdef REG_FILE_BYPASS_EN
        if (bus.CLEAR) return 32'h0;
        if (bus.WRITE && bus.ADDR_W == a) return bus.DATA_W;
`endif
        return m_mem[a];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_mem[i] <= 32'h0;
            m_r1 <= 32'h0;
            m_r2 <= 32'h0;
            m_v  <= 1'b0;
        end else begin
            m_v <= bus.READ;
            if (bus.READ) begin
                m_r1 <= model_read(bus.ADDR_R1);
                m_r2 <= model_read(bus.ADDR_R2);
            end
            if (bus.CLEAR) begin
                for (int i = 0; i < 32; i++) m_mem[i] <= 32'h0;
            end else if (bus.WRITE) begin
                m_mem[bus.ADDR_W] <= bus.DATA_W;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            checks = checks + 3;
            if (bus.DATA_R1 !== m_r1) begin
                errors++;
                $display("FAIL cyc_r1 t=%0t: got %h expected %h", $time, bus.DATA_R1, m_r1);
            end
            if (bus.DATA_R2 !== m_r2) begin
                errors++;
                $display("FAIL cyc_r2 t=%0t: got %h expected %h", $time, bus.DATA_R2, m_r2);
            end
            if (bus.RD_VALID !== m_v) begin
                errors++;
                $display("FAIL cyc_valid t=%0t: got %b expected %b", $time, bus.RD_VALID, m_v);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One operation at the next rising edge; returns at edge+1 with strobes idle.
    task automatic cyc(input logic rd, input logic wr, input logic clr,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] aw, input logic [31:0] dw);
        bus.READ = rd; bus.WRITE = wr; bus.CLEAR = clr;
        bus.ADDR_R1 = a1; bus.ADDR_R2 = a2; bus.ADDR_W = aw; bus.DATA_W = dw;
        @(posedge clk);
        #1;
        bus.READ = 1'b0; bus.WRITE = 1'b0; bus.CLEAR = 1'b0;
    endtask

    task automatic cyc8(input logic rd, input logic wr,
                        input logic [1:0] a1, input logic [1:0] a2,
                        input logic [1:0] aw, input logic [7:0] dw);
        bus8.READ = rd; bus8.WRITE = wr; bus8.CLEAR = 1'b0;
        bus8.ADDR_R1 = a1; bus8.ADDR_R2 = a2; bus8.ADDR_W = aw; bus8.DATA_W = dw;
        @(posedge clk);
        #1;
        bus8.READ = 1'b0; bus8.WRITE = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_coll;
        logic [31:0] exp_clr9;
        logic [31:0] exp_clr20;

        bus.READ = 0; bus.WRITE = 0; bus.CLEAR = 0;
        bus.ADDR_R1 = 0; bus.ADDR_R2 = 0; bus.ADDR_W = 0; bus.DATA_W = 0;
        bus8.READ = 0; bus8.WRITE = 0; bus8.CLEAR = 0;
        bus8.ADDR_R1 = 0; bus8.ADDR_R2 = 0; bus8.ADDR_W = 0; bus8.DATA_W = 0;

        #1 rst = 1'b1;
        #1 cmp_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_r1", bus.DATA_R1, 32'h0);
        check("reset_r2", bus.DATA_R2, 32'h0);
        check("reset_valid", {31'h0, bus.RD_VALID}, 32'h0);

        // Make the outputs non-zero, then assert reset mid-cycle with READ high.
        cyc(0, 1, 0, 0, 0, 5'd7, 32'h1234_5678);
        cyc(1, 0, 0, 5'd7, 5'd7, 0, 0);
        check("pre_rst_r1", bus.DATA_R1, 32'h1234_5678);
        bus.READ = 1'b1; bus.WRITE = 1'b1; bus.ADDR_W = 5'd7; bus.DATA_W = 32'h77;
        #2 rst = 1'b1;
        #1;
        check("midrst_r1", bus.DATA_R1, 32'h0);
        check("midrst_r2", bus.DATA_R2, 32'h0);
        check("midrst_valid", {31'h0, bus.RD_VALID}, 32'h0);
        repeat (2) @(posedge clk);
        #1 bus.READ = 1'b0; bus.WRITE = 1'b0;
        #2 rst = 1'b0;
        cyc(1, 0, 0, 5'd7, 5'd3, 0, 0);
        check("post_rst_addr7", bus.DATA_R1, 32'h0);

        // Write then read; valid pulses once; hold while writing.
        cyc(0, 1, 0, 0, 0, 5'd3, 32'hDEAD_BEEF);
        cyc(1, 0, 0, 5'd3, 5'd0, 0, 0);
        check("wr_rd_r1", bus.DATA_R1, 32'hDEAD_BEEF);
        check("wr_rd_r2", bus.DATA_R2, 32'h0);
        check("wr_rd_valid", {31'h0, bus.RD_VALID}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 0, 5'd3, 5'd0, 5'd3, 32'h1);
            check("hold_r1", bus.DATA_R1, 32'hDEAD_BEEF);
            check("hold_valid", {31'h0, bus.RD_VALID}, 32'h0);
        end
        cyc(1, 0, 0, 5'd3, 5'd3, 0, 0);
        check("hold_after_r1", bus.DATA_R1, 32'h1);

        // Read/write collision on addr 5; both ports on the same address.
        cyc(0, 1, 0, 0, 0, 5'd5, 32'hA);
`ifdef REG_FILE_BYPASS_EN
        exp_coll = 32'hB;
`else
        exp_coll = 32'hA;
`endif
        cyc(1, 1, 0, 5'd5, 5'd5, 5'd5, 32'hB);
        check("coll_r1", bus.DATA_R1, exp_coll);
        check("coll_r2", bus.DATA_R2, exp_coll);
        cyc(1, 0, 0, 5'd5, 5'd3, 0, 0);
        check("coll_later", bus.DATA_R1, 32'hB);

        // Back-to-back writes to one address keep the last value.
        cyc(0, 1, 0, 0, 0, 5'd12, 32'h1);
        cyc(0, 1, 0, 0, 0, 5'd12, 32'h2);
        cyc(0, 1, 0, 0, 0, 5'd12, 32'h3);
        cyc(1, 0, 0, 5'd12, 5'd12, 0, 0);
        check("b2b_r1", bus.DATA_R1, 32'h3);

        // Fill every entry, read every address back through the model.
        for (int i = 0; i < 32; i++) cyc(0, 1, 0, 0, 0, 5'(i), 32'hC0DE_0000 | 32'(i));
        for (int i = 0; i < 32; i++) cyc(1, 0, 0, 5'(i), 5'(31 - i), 0, 0);
        cyc(1, 0, 0, 5'd0, 5'd31, 0, 0);
        check("fill_r1", bus.DATA_R1, 32'hC0DE_0000);
        check("fill_r2", bus.DATA_R2, 32'hC0DE_001F);

        // Clear wins over a same-cycle write.
`ifdef REG_FILE_BYPASS_EN
        exp_clr9 = 32'h0;
        exp_clr20 = 32'h0;
`else
        exp_clr9 = 32'hC0DE_0009;
        exp_clr20 = 32'hC0DE_0014;
`endif
        cyc(1, 1, 1, 5'd9, 5'd20, 5'd9, 32'h55);
        check("clr_same_r1", bus.DATA_R1, exp_clr9);
        check("clr_same_r2", bus.DATA_R2, exp_clr20);
        for (int i = 0; i < 32; i++) begin
            cyc(1, 0, 0, 5'(i), 5'(i ^ 9), 0, 0);
            check("clr_r1", bus.DATA_R1, 32'h0);
        end

        // Narrow build: 8-bit data, 4 entries.
        cyc8(0, 1, 2'd0, 2'd0, 2'd3, 8'hFF);
        cyc8(0, 1, 2'd0, 2'd0, 2'd0, 8'h01);
        cyc8(1, 0, 2'd3, 2'd0, 2'd0, 8'h00);
        check("p8_r1", {24'h0, bus8.DATA_R1}, 32'hFF);
        check("p8_r2", {24'h0, bus8.DATA_R2}, 32'h01);
        check("p8_valid", {31'h0, bus8.RD_VALID}, 32'h1);
        cyc8(1, 0, 2'd1, 2'd2, 2'd0, 8'h00);
        check("p8_r1_empty", {24'h0, bus8.DATA_R1}, 32'h0);
        check("p8_r2_empty", {24'h0, bus8.DATA_R2}, 32'h0);

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 The block SHALL have one clock, CLK, and an asynchronous, active-high reset, RESET.
REQ-002 Parameter DATA_WIDTH, default 32: width in bits of every entry and data port.
REQ-003 Parameter ADDR_WIDTH, default 5: address width; DEPTH = 2^ADDR_WIDTH entries.
REQ-004 CLK  input  1  rising-edge clock for all state.
REQ-005 RESET  input  1  asynchronous active-high reset of all state.
REQ-006 READ  input  1  read request, sampled at the CLK rising edge.
REQ-007 WRITE  input  1  write request, sampled at the CLK rising edge.
REQ-008 CLEAR  input  1  synchronous clear of all entries.
REQ-009 ADDR_R1  input  ADDR_WIDTH  read port 1 address.
REQ-010 ADDR_R2  input  ADDR_WIDTH  read port 2 address.
REQ-011 ADDR_W  input  ADDR_WIDTH  write address.
REQ-012 DATA_W  input  DATA_WIDTH  write data.
REQ-013 DATA_R1  output  DATA_WIDTH  registered read data, port 1.
REQ-014 DATA_R2  output  DATA_WIDTH  registered read data, port 2.
REQ-015 RD_VALID  output  1  high for one cycle when DATA_R1/DATA_R2 were updated by a read.

Function
REQ-016 Storage SHALL be DEPTH entries of DATA_WIDTH bits, each updated only on a CLK rising edge.
REQ-017 When WRITE=1 and CLEAR=0 at an edge, entry[ADDR_W] SHALL take DATA_W; all other entries SHALL hold.
REQ-018 When CLEAR=1 at an edge, all entries SHALL become 0 and any same-cycle write SHALL be dropped (CLEAR has priority).
REQ-019 When READ=1 at an edge, DATA_R1 SHALL take entry[ADDR_R1] and DATA_R2 SHALL take entry[ADDR_R2] (read latency 1 cycle), and RD_VALID SHALL be 1 for the following cycle.
REQ-020 When READ=0 at an edge, DATA_R1 and DATA_R2 SHALL hold their values and RD_VALID SHALL be 0.
REQ-021 Both read ports SHALL operate independently; ADDR_R1=ADDR_R2 SHALL return identical data on both ports.
REQ-022 Read and write to the same address in one cycle: the read result SHALL be defined by REQ-027/REQ-028.
REQ-023 Every address 0..DEPTH-1 SHALL be writable and readable; no entry is hardwired.
REQ-024 Back-to-back writes to the same address SHALL leave the last-written value; there is no write backpressure.

Reset
REQ-025 On RESET=1, asynchronously: all entries = 0, DATA_R1 = 0, DATA_R2 = 0, RD_VALID = 0.
REQ-026 A READ, WRITE or CLEAR coinciding with RESET=1, or with the edge at which RESET deasserts, SHALL have no effect; operation resumes at the first edge with RESET=0.

Configuration
REQ-027 Without REG_FILE_BYPASS_EN defined, a same-cycle read of an address being written or cleared SHALL return the pre-edge stored value.
REQ-028 With REG_FILE_BYPASS_EN defined, that read SHALL return the committed value: DATA_W for a write (CLEAR=0), or 0 when CLEAR=1; reads of other addresses SHALL be unaffected.

Verification
REQ-029 Reset: assert RESET mid-cycle with READ=1 -> DATA_R1=DATA_R2=0 and RD_VALID=0 immediately; after release, read addr 7 -> 0.
REQ-030 Write/read: write 0xDEADBEEF to addr 3, then READ with ADDR_R1=3, ADDR_R2=0 -> next cycle DATA_R1=0xDEADBEEF, DATA_R2=0, RD_VALID=1 for exactly one cycle.
REQ-031 Hold: after REQ-030, READ=0 for 3 cycles while writing addr 3 = 0x1 -> DATA_R1 stays 0xDEADBEEF and RD_VALID=0.
REQ-032 Collision: addr 5 = 0xA, same cycle WRITE addr 5 = 0xB and READ ADDR_R1=5 -> DATA_R1=0xA without the macro, 0xB with REG_FILE_BYPASS_EN; a later read returns 0xB in both builds.
REQ-033 Clear priority: fill all 32 entries, then CLEAR=1 with WRITE addr 9 = 0x55 -> every subsequent read returns 0, including addr 9.
REQ-034 Parameters: DATA_WIDTH=8, ADDR_WIDTH=2; write 0xFF to addr 3 and 0x01 to addr 0 -> reads return 0xFF and 0x01; addresses wrap only within 0..3.
